// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered, handshaked ALU-select decoder between IR3 and execute
// Ports:
//   clk, reset_n          clock (rising edge), synchronous active-low reset
//   ir_in/in_valid/in_ready       instruction input handshake
//   flush                 drop held decode and cancel the MUL hold
//   ir_out/alu_select/illegal/out_valid/out_ready  registered decode output handshake
//   illegal_cnt           saturating count of accepted illegal instructions
module alu_decode_stage #(
    parameter int XLEN    = 32,
    parameter int SEL_W   = 6,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [XLEN-1:0]  ir_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [XLEN-1:0]  ir_out,
    output logic [SEL_W-1:0] alu_select,
    output logic             illegal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam int MW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [SEL_W-1:0] SEL_MUL = SEL_W'(6'b001010);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [5:0] code;
    logic hit, accept, hs;
    logic [SEL_W-1:0] dec_sel;
    logic [XLEN-1:0] ir_out_d, ir_out_q;
    logic [SEL_W-1:0] alu_select_d, alu_select_q;
    logic illegal_d, illegal_q, out_valid_d, out_valid_q;
    logic [CNT_W-1:0] illegal_cnt_d, illegal_cnt_q;
    logic [MW-1:0] mul_cnt_d, mul_cnt_q;
    assign op = ir_in[6:0];
    assign f3 = ir_in[14:12];
    assign f7 = ir_in[31:25];
    always_comb begin
        code = 6'd0;
        hit  = 1'b1;
        case (op)
            7'b0110011:
                case ({f7, f3})
                    {7'b0100000, 3'b000}: code = 6'b000000;
                    {7'b0000000, 3'b000}: code = 6'b000001;
                    {7'b0000000, 3'b111}: code = 6'b000010;
                    {7'b0000000, 3'b110}: code = 6'b000011;
                    {7'b0000000, 3'b100}: code = 6'b000100;
                    {7'b0000000, 3'b010}: code = 6'b000101;
                    {7'b0000000, 3'b011}: code = 6'b000110;
                    {7'b0100000, 3'b101}: code = 6'b000111;
                    {7'b0000000, 3'b101}: code = 6'b001000;
                    {7'b0000000, 3'b001}: code = 6'b001001;
                    {7'b0000001, 3'b000}: code = 6'b001010;
                    default:              hit  = 1'b0;
                endcase
            7'b0010011:
                case (f3)
                    3'b000: code = 6'b001011;
                    3'b001: code = 6'b001100;
                    3'b111: code = 6'b001101;
                    3'b110: code = 6'b001110;
                    3'b100: code = 6'b001111;
                    3'b010: code = 6'b010000;
                    3'b011: code = 6'b010001;
                    default:
                        case (f7)
                            7'b0100000: code = 6'b010010;
                            7'b0000000: code = 6'b010011;
                            7'b0000001: code = 6'b010100;
                            default:    hit  = 1'b0;
                        endcase
                endcase
            7'b0110111: code = 6'b010101;
            7'b0010111: code = 6'b010110;
            7'b0000011: begin
                code = 6'b010111;
                hit  = f3 == 3'b010;
            end
            7'b0100011: begin
                code = 6'b011000;
                hit  = f3 == 3'b010;
            end
            7'b1101111:
                code = (ir_in[14:7] == 8'd0 && ir_in[31:20] == 12'd0) ? 6'b011001 :
                       (f3 == 3'b000) ? 6'b011010 : 6'b011011;
            7'b1100011:
                case (f3)
                    3'b000:  code = 6'b011100;
                    3'b001:  code = 6'b011101;
                    3'b100:  code = 6'b011110;
                    3'b101:  code = 6'b011111;
                    3'b110:  code = 6'b100000;
                    3'b111:  code = 6'b100001;
                    default: hit  = 1'b0;
                endcase
            default: hit = 1'b0;
        endcase
        dec_sel = hit ? SEL_W'(code) : '1;
    end
    assign in_ready = (!out_valid_q || out_ready) && mul_cnt_q == '0 && !flush;
    assign accept   = in_valid && in_ready;
    assign hs       = out_valid_q && out_ready;
    always_comb begin
        ir_out_d      = accept ? ir_in : ir_out_q;
        alu_select_d  = accept ? dec_sel : alu_select_q;
        illegal_d     = accept ? !hit : illegal_q;
        out_valid_d   = flush ? 1'b0 : accept ? 1'b1 : hs ? 1'b0 : out_valid_q;
        illegal_cnt_d = (accept && !hit && illegal_cnt_q != '1) ? illegal_cnt_q + CNT_W'(1) : illegal_cnt_q;
        // the MUL load takes precedence over the running decrement
        mul_cnt_d     = flush ? '0 :
                        (MUL_LAT > 1 && hs && alu_select_q == SEL_MUL) ? MW'(MUL_LAT - 1) :
                        (mul_cnt_q != '0) ? mul_cnt_q - MW'(1) : '0;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ir_out_q      <= '0;
            alu_select_q  <= '0;
            illegal_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            illegal_cnt_q <= '0;
            mul_cnt_q     <= '0;
        end else begin
            ir_out_q      <= ir_out_d;
            alu_select_q  <= alu_select_d;
            illegal_q     <= illegal_d;
            out_valid_q   <= out_valid_d;
            illegal_cnt_q <= illegal_cnt_d;
            mul_cnt_q     <= mul_cnt_d;
        end
    end
    assign ir_out      = ir_out_q;
    assign alu_select  = alu_select_q;
    assign illegal     = illegal_q;
    assign out_valid   = out_valid_q;
    assign illegal_cnt = illegal_cnt_q;
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed plus randomized checks against a table-driven reference model
module tb_alu_decode_stage;
    localparam int MUL_LAT = 3;
    logic clk, reset_n, in_valid, in_ready, flush, out_valid, out_ready, illegal;
    logic [31:0] ir_in, ir_out;
    logic [5:0] alu_select;
    logic [7:0] illegal_cnt;
    logic s_in_ready, s_out_valid, s_illegal;
    logic [31:0] s_ir_out;
    logic [5:0] s_alu_select;
    logic [1:0] s_illegal_cnt;
    int checks = 0, passed = 0, fails = 0;
    logic [31:0] t_mask[$], t_match[$];
    int t_code[$];
    int m_valid, m_sel, m_ill, m_cnt8, m_cnt2, m_hold;
    logic [31:0] m_ir;

    alu_decode_stage #(.XLEN(32), .SEL_W(6), .MUL_LAT(MUL_LAT), .CNT_W(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .ir_out(ir_out), .alu_select(alu_select), .illegal(illegal),
        .out_valid(out_valid), .out_ready(out_ready), .illegal_cnt(illegal_cnt));

    alu_decode_stage #(.XLEN(32), .SEL_W(6), .MUL_LAT(MUL_LAT), .CNT_W(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .in_valid(in_valid), .in_ready(s_in_ready),
        .flush(flush), .ir_out(s_ir_out), .alu_select(s_alu_select), .illegal(s_illegal),
        .out_valid(s_out_valid), .out_ready(out_ready), .illegal_cnt(s_illegal_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [31:0] mask, input logic [31:0] match, input int code);
        t_mask.push_back(mask);
        t_match.push_back(match);
        t_code.push_back(code);
    endtask

    task automatic rr(input logic [6:0] f7, input logic [2:0] f3, input int code, input logic [6:0] op);
        add(32'hFE00707F, {f7, 10'b0, f3, 5'b0, op}, code);
    endtask

    task automatic f3_only(input logic [2:0] f3, input int code, input logic [6:0] op);
        add(32'h0000707F, {17'b0, f3, 5'b0, op}, code);
    endtask

    function automatic int ref_dec(input logic [31:0] x);
        foreach (t_mask[i]) if ((x & t_mask[i]) == t_match[i]) return t_code[i];
        return 63;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [31:0] ir, input logic ordy, input logic fl, input logic rn);
        logic rdy, acc, hs;
        int code;
        in_valid = iv; ir_in = ir; out_ready = ordy; flush = fl; reset_n = rn;
        #1;
        rdy = (m_valid == 0 || ordy) && m_hold == 0 && !fl;
        chk("in_ready", in_ready, rdy);
        chk("sat_in_ready", s_in_ready, rdy);
        acc  = iv && rdy;
        hs   = m_valid != 0 && ordy;
        code = ref_dec(ir);
        @(posedge clk);
        if (!rn) begin
            m_valid = 0; m_sel = 0; m_ill = 0; m_ir = 0; m_cnt8 = 0; m_cnt2 = 0; m_hold = 0;
        end else begin
            if (acc && code == 63) begin
                m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
            if (fl) m_hold = 0;
            else if (hs && m_sel == 10 && MUL_LAT > 1) m_hold = MUL_LAT - 1;
            else if (m_hold > 0) m_hold = m_hold - 1;
            if (fl) m_valid = 0;
            else if (acc) begin
                m_valid = 1; m_sel = code; m_ill = (code == 63) ? 1 : 0; m_ir = ir;
            end else if (hs) m_valid = 0;
        end
        #1;
        chk("out_valid", out_valid, 64'(m_valid));
        chk("alu_select", alu_select, 64'(m_sel));
        chk("illegal", illegal, 64'(m_ill));
        chk("ir_out", ir_out, 64'(m_ir));
        chk("illegal_cnt", illegal_cnt, 64'(m_cnt8));
        chk("sat_illegal_cnt", s_illegal_cnt, 64'(m_cnt2));
        chk("sat_alu_select", s_alu_select, 64'(m_sel));
    endtask

    initial begin
        logic [31:0] ins;
        rr(7'b0100000, 3'b000, 0, 7'h33);  rr(7'b0000000, 3'b000, 1, 7'h33);
        rr(7'b0000000, 3'b111, 2, 7'h33);  rr(7'b0000000, 3'b110, 3, 7'h33);
        rr(7'b0000000, 3'b100, 4, 7'h33);  rr(7'b0000000, 3'b010, 5, 7'h33);
        rr(7'b0000000, 3'b011, 6, 7'h33);  rr(7'b0100000, 3'b101, 7, 7'h33);
        rr(7'b0000000, 3'b101, 8, 7'h33);  rr(7'b0000000, 3'b001, 9, 7'h33);
        rr(7'b0000001, 3'b000, 10, 7'h33);
        f3_only(3'b000, 11, 7'h13); f3_only(3'b001, 12, 7'h13); f3_only(3'b111, 13, 7'h13);
        f3_only(3'b110, 14, 7'h13); f3_only(3'b100, 15, 7'h13); f3_only(3'b010, 16, 7'h13);
        f3_only(3'b011, 17, 7'h13);
        rr(7'b0100000, 3'b101, 18, 7'h13); rr(7'b0000000, 3'b101, 19, 7'h13);
        rr(7'b0000001, 3'b101, 20, 7'h13);
        add(32'h0000007F, 32'h37, 21);
        add(32'h0000007F, 32'h17, 22);
        f3_only(3'b010, 23, 7'h03);
        f3_only(3'b010, 24, 7'h23);
        add(32'hFFF07FFF, 32'h6F, 25);
        f3_only(3'b000, 26, 7'h6F);
        add(32'h0000007F, 32'h6F, 27);
        f3_only(3'b000, 28, 7'h63); f3_only(3'b001, 29, 7'h63); f3_only(3'b100, 30, 7'h63);
        f3_only(3'b101, 31, 7'h63); f3_only(3'b110, 32, 7'h63); f3_only(3'b111, 33, 7'h63);
        in_valid = 0; ir_in = 0; out_ready = 0; flush = 0; reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        m_valid = 0; m_sel = 0; m_ill = 0; m_ir = 0; m_cnt8 = 0; m_cnt2 = 0; m_hold = 0;
        step(0, 0, 1, 0, 0);
        step(1, 32'h00000033, 1, 0, 1);
        step(1, 32'h40000033, 1, 0, 1);
        step(1, 32'h00007033, 1, 0, 1);
        step(1, 32'h00500093, 1, 0, 1);
        step(1, 32'h40305013, 1, 0, 1);
        repeat (3) step(1, 32'h00001033, 0, 0, 1);
        step(1, 32'h00001033, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        step(1, 32'h02000033, 1, 0, 1);
        repeat (4) step(1, 32'h00000013, 1, 0, 1);
        repeat (3) step(0, 0, 1, 0, 1);
        step(1, 32'h0000207F, 1, 0, 1);
        step(1, 32'h00002063, 1, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 32'h0000007F | (i << 12), 1, 0, 1);
        step(0, 0, 1, 0, 1);
        step(1, 32'h00000033, 0, 0, 1);
        step(1, 32'h00000013, 0, 1, 1);
        step(0, 0, 1, 0, 1);
        step(1, 32'h02000033, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 1, 1);
        step(1, 32'h00000013, 1, 0, 1);
        step(1, 32'h02000033, 0, 0, 1);
        step(1, 32'h00000013, 1, 0, 1);
        step(1, 32'h00000013, 0, 0, 1);
        step(1, 32'h00000013, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       ins = $urandom;
                1, 2:    ins = ($urandom & 32'h01FF8F80) | 32'h02000033;
                default: begin
                    int k;
                    k = $urandom_range(0, t_mask.size() - 1);
                    ins = ($urandom & ~t_mask[k]) | t_match[k];
                end
            endcase
            step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 49) != 0);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
